// File: rtl/pipeline_ctrl.sv
// Pipeline control for a 5-stage in-order core: stall/flush generation, operand forwarding
// select, memory and mul/div wait FSM with timeout, and a stalled-cycle counter.
module pipeline_ctrl #(
  parameter int unsigned TIMEOUT = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  d_rs1_i,
  input  logic [4:0]  d_rs2_i,
  input  logic        d_use1_i,
  input  logic        d_use2_i,
  input  logic [4:0]  e_rs1_i,
  input  logic [4:0]  e_rs2_i,
  input  logic [4:0]  e_rd_i,
  input  logic        e_is_load_i,
  input  logic        e_reg_write_i,
  input  logic [4:0]  m_rd_i,
  input  logic [4:0]  w_rd_i,
  input  logic        m_reg_write_i,
  input  logic        w_reg_write_i,
  input  logic        e_redirect_i,
  input  logic        dmem_req_i,
  input  logic        dmem_ack_i,
  input  logic        md_start_i,
  input  logic        md_done_i,
  output logic        pc_en_o,
  output logic        fd_en_o,
  output logic        fd_flush_o,
  output logic        de_en_o,
  output logic        de_flush_o,
  output logic        em_en_o,
  output logic        em_flush_o,
  output logic        mw_en_o,
  output logic [1:0]  fwd_a_o,
  output logic [1:0]  fwd_b_o,
  output logic [1:0]  state_o,
  output logic        err_o,
  output logic [31:0] stall_cnt_o
);

  localparam logic [1:0] StRun     = 2'b00;
  localparam logic [1:0] StMemWait = 2'b01;
  localparam logic [1:0] StMdWait  = 2'b10;

  localparam int unsigned CntW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
  localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT - 1);

  logic [1:0]      state_q, state_d;
  logic [CntW-1:0] wait_cnt_q, wait_cnt_d;
  logic            err_q, err_d;
  logic [31:0]     stall_cnt_q, stall_cnt_d;

  logic mem_stall, md_stall, load_use, timeout_hit;

  assign mem_stall   = dmem_req_i & ~dmem_ack_i;
  assign md_stall    = md_start_i & ~md_done_i;
  assign load_use    = e_is_load_i & e_reg_write_i & (e_rd_i != 5'd0) &
                       ((d_use1_i & (e_rd_i == d_rs1_i)) | (d_use2_i & (e_rd_i == d_rs2_i)));
  assign timeout_hit = (wait_cnt_q == CntLast);

  always_comb begin
    pc_en_o    = 1'b1;
    fd_en_o    = 1'b1;
    fd_flush_o = 1'b0;
    de_en_o    = 1'b1;
    de_flush_o = 1'b0;
    em_en_o    = 1'b1;
    em_flush_o = 1'b0;
    mw_en_o    = 1'b1;
    state_d    = StRun;
    wait_cnt_d = wait_cnt_q;
    err_d      = err_q;

    case (state_q)
      StMemWait: begin
        {pc_en_o, fd_en_o, de_en_o, em_en_o, mw_en_o} = 5'b00000;
        if (dmem_ack_i) begin
          state_d = StRun;
        end else if (timeout_hit) begin
          state_d = StRun;
          err_d   = 1'b1;
        end else begin
          state_d    = StMemWait;
          wait_cnt_d = wait_cnt_q + 1'b1;
        end
      end
      StMdWait: begin
        {pc_en_o, fd_en_o, de_en_o} = 3'b000;
        em_flush_o = 1'b1;
        if (md_done_i) begin
          state_d = StRun;
        end else if (timeout_hit) begin
          state_d = StRun;
          err_d   = 1'b1;
        end else begin
          state_d    = StMdWait;
          wait_cnt_d = wait_cnt_q + 1'b1;
        end
      end
      // StRun and the unreachable 2'b11 encoding.
      default: begin
        if (mem_stall) begin
          {pc_en_o, fd_en_o, de_en_o, em_en_o, mw_en_o} = 5'b00000;
          state_d    = StMemWait;
          wait_cnt_d = '0;
        end else if (md_stall) begin
          {pc_en_o, fd_en_o, de_en_o} = 3'b000;
          em_flush_o = 1'b1;
          state_d    = StMdWait;
          wait_cnt_d = '0;
        end else if (e_redirect_i) begin
          fd_flush_o = 1'b1;
          de_flush_o = 1'b1;
        end else if (load_use) begin
          pc_en_o    = 1'b0;
          fd_en_o    = 1'b0;
          de_flush_o = 1'b1;
        end
      end
    endcase

    stall_cnt_d = stall_cnt_q;
    if (!pc_en_o && (stall_cnt_q != 32'hFFFF_FFFF)) begin
      stall_cnt_d = stall_cnt_q + 32'd1;
    end
  end

  // M has priority over W since it holds the younger result.
  always_comb begin
    fwd_a_o = 2'b00;
    if (m_reg_write_i && (m_rd_i != 5'd0) && (m_rd_i == e_rs1_i)) begin
      fwd_a_o = 2'b01;
    end else if (w_reg_write_i && (w_rd_i != 5'd0) && (w_rd_i == e_rs1_i)) begin
      fwd_a_o = 2'b10;
    end
    fwd_b_o = 2'b00;
    if (m_reg_write_i && (m_rd_i != 5'd0) && (m_rd_i == e_rs2_i)) begin
      fwd_b_o = 2'b01;
    end else if (w_reg_write_i && (w_rd_i != 5'd0) && (w_rd_i == e_rs2_i)) begin
      fwd_b_o = 2'b10;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= StRun;
      wait_cnt_q  <= '0;
      err_q       <= 1'b0;
      stall_cnt_q <= 32'd0;
    end else begin
      state_q     <= state_d;
      wait_cnt_q  <= wait_cnt_d;
      err_q       <= err_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign state_o     = state_q;
  assign err_o       = err_q;
  assign stall_cnt_o = stall_cnt_q;

endmodule

// File: doc/pipeline_ctrl.md
PIPELINE_CTRL -- requirements
Module: pipeline_ctrl

Interface
REQ-001 SHALL have parameter TIMEOUT, default 64, max cycles in any wait state before err is set.
REQ-002 SHALL have port clk  input  1  clock, all state updates on rising edge.
REQ-003 SHALL have port reset  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have ports d_rs1, d_rs2  input  5 each  decode-stage source registers; d_use1, d_use2  input  1 each  source actually read.
REQ-005 SHALL have ports e_rs1, e_rs2, e_rd  input  5 each  execute-stage registers; e_is_load, e_reg_write  input  1 each.
REQ-006 SHALL have ports m_rd, w_rd  input  5 each; m_reg_write, w_reg_write  input  1 each.
REQ-007 SHALL have port e_redirect  input  1  taken branch/jump resolved in execute.
REQ-008 SHALL have ports dmem_req, dmem_ack  input  1 each  memory-stage data access request and completion.
REQ-009 SHALL have ports md_start, md_done  input  1 each  multi-cycle mul/div in execute and its completion.
REQ-010 SHALL have outputs pc_en, fd_en, fd_flush, de_en, de_flush, em_en, em_flush, mw_en  1 each  pipeline register controls.
REQ-011 SHALL have outputs fwd_a, fwd_b  2 each  execute operand select: 00 register file, 01 from M, 10 from W.
REQ-012 SHALL have outputs state  2  current FSM state; err  1  sticky timeout flag; stall_cnt  32  stalled-cycle count.

Function
REQ-013 SHALL implement FSM states RUN=00, MEM_WAIT=01, MD_WAIT=10; 11 unreachable, decoded as RUN.
REQ-014 RUN->MEM_WAIT SHALL occur when dmem_req=1 and dmem_ack=0; MEM_WAIT->RUN on the cycle dmem_ack=1 is sampled.
REQ-015 RUN->MD_WAIT SHALL occur when md_start=1, md_done=0 and no MEM_WAIT entry that cycle; MD_WAIT->RUN on md_done=1.
REQ-016 MEM_WAIT SHALL take priority over MD_WAIT when both conditions hold in the same cycle.
REQ-017 In MEM_WAIT (and in RUN while dmem_req=1, dmem_ack=0): pc_en=fd_en=de_en=em_en=mw_en=0, all flushes 0.
REQ-018 In MD_WAIT (and in RUN while md_start=1, md_done=0, no memory stall): pc_en=fd_en=de_en=0, em_en=1, em_flush=1, mw_en=1.
REQ-019 Load-use hazard SHALL be e_is_load & e_reg_write & e_rd!=0 & ((d_use1 & e_rd==d_rs1) | (d_use2 & e_rd==d_rs2)).
REQ-020 Load-use in RUN with no wait condition SHALL drive pc_en=0, fd_en=0, de_en=1, de_flush=1, em_en=mw_en=1 (one bubble, one cycle).
REQ-021 e_redirect in RUN with no wait condition SHALL drive fd_flush=1, de_flush=1, all enables 1; redirect overrides load-use.
REQ-022 e_redirect during a wait condition SHALL be ignored; execute is frozen so it is re-presented on exit.
REQ-023 Default in RUN with no hazard: all enables 1, all flushes 0.
REQ-024 fwd_a SHALL be 01 if m_reg_write & m_rd!=0 & m_rd==e_rs1, else 10 if w_reg_write & w_rd!=0 & w_rd==e_rs1, else 00; fwd_b likewise with e_rs2; combinational, valid in every state.
REQ-025 A wait counter SHALL clear on entering a wait state and increment each cycle in it; reaching TIMEOUT SHALL set err=1 and force next state RUN.
REQ-026 err SHALL remain 1 until reset.
REQ-027 stall_cnt SHALL increment on every cycle with pc_en=0 and saturate at 32'hFFFFFFFF.
REQ-028 All control outputs SHALL be combinational from state and inputs; only state, wait counter, err, stall_cnt are registered.

Reset
REQ-029 Reset SHALL force state=RUN, wait counter=0, err=0, stall_cnt=0 immediately, including mid-wait.
REQ-030 During reset, control outputs SHALL follow RUN decoding of current inputs.

Verification
REQ-031 e_is_load=1, e_reg_write=1, e_rd=5, d_rs1=5, d_use1=1 -> one cycle pc_en=0, fd_en=0, de_flush=1; stall_cnt +1.
REQ-032 Same load-use plus e_redirect=1 -> fd_flush=1, de_flush=1, pc_en=1; stall_cnt unchanged.
REQ-033 dmem_req=1, dmem_ack low 3 cycles then high -> state 01 for 3 cycles, all enables 0, back to 00; stall_cnt +4.
REQ-034 md_start=1, md_done after 5 cycles -> state 10, em_flush=1, mw_en=1 throughout; returns to 00.
REQ-035 m_rd=w_rd=e_rs1=7, both reg_write=1 -> fwd_a=01; m_rd=0 -> fwd_a=10; e_rs1=0 -> 00.
REQ-036 TIMEOUT=4, dmem_ack never asserted -> err=1 after 4 wait cycles, state RUN; reset mid-wait -> state 00, err=0, stall_cnt=0.
